// File: rtl/fc_loss_unit.sv
// Scores FC_OUTPUT_SIZE FC-layer outputs against a one-hot label: argmax, correct flag, saturating SSE loss.
// Optional GT_CHECK_EN macro adds err_gt and rejects labels that are not exactly one-hot.
//
// state | meaning
// IDLE  | waiting for start; results from the previous image held
// ACCUM | accepting samples, accumulating loss and tracking argmax
// DONE  | one-cycle done pulse, results valid
module fc_loss_unit #(
    parameter int FC_OUTPUT_SIZE = 10,
    parameter int DATA_W         = 32,
    parameter int LOSS_W         = 32,
    parameter int TARGET_ONE     = 256
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic [FC_OUTPUT_SIZE-1:0]         ground_truth,
    input  logic                              in_valid,
    input  logic signed [DATA_W-1:0]          in_data,
    output logic                              in_ready,
    output logic                              busy,
    output logic                              done,
    output logic [$clog2(FC_OUTPUT_SIZE)-1:0] pred_class,
    output logic                              correct,
`ifdef GT_CHECK_EN
    output logic [LOSS_W-1:0]                 loss,
    output logic                              err_gt
`else
    output logic [LOSS_W-1:0]                 loss
`endif
);

    localparam int IDX_W  = $clog2(FC_OUTPUT_SIZE);
    localparam int DIFF_W = DATA_W + 1;
    localparam int SQ_W   = 2 * DIFF_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FC_OUTPUT_SIZE - 1);
    localparam logic [SQ_W:0]    LOSS_MAX = {{(SQ_W + 1 - LOSS_W){1'b0}}, {LOSS_W{1'b1}}};

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t                     state, state_nxt;
    logic [FC_OUTPUT_SIZE-1:0]  gt_lat;
    logic [IDX_W-1:0]           cnt;
    logic [LOSS_W-1:0]          acc;
    logic signed [DATA_W-1:0]   max_val;
    logic [IDX_W-1:0]           max_idx;

    logic                       xfer, last_xfer, start_ok, gt_bad;
    logic signed [DIFF_W-1:0]   target, diff;
    logic signed [SQ_W-1:0]     sq;
    logic [SQ_W:0]              sum_ext;
    logic [LOSS_W-1:0]          acc_nxt;
    logic signed [DATA_W-1:0]   max_val_nxt;
    logic [IDX_W-1:0]           max_idx_nxt;

    assign xfer      = in_valid && (state == ACCUM);
    assign last_xfer = xfer && (cnt == LAST_IDX);
    assign start_ok  = start && (state == IDLE);

`ifdef GT_CHECK_EN
    assign gt_bad = ($countones(ground_truth) != 1);
`else
    assign gt_bad = 1'b0;
`endif

    assign target  = gt_lat[cnt] ? DIFF_W'(TARGET_ONE) : '0;
    assign diff    = {in_data[DATA_W-1], in_data} - target;
    assign sq      = diff * diff;
    // One spare bit on the sum catches overflow; saturation is sticky since sum >= acc.
    assign sum_ext = {1'b0, sq} + {{(SQ_W + 1 - LOSS_W){1'b0}}, acc};
    assign acc_nxt = (sum_ext > LOSS_MAX) ? '1 : sum_ext[LOSS_W-1:0];

    always_comb begin
        max_val_nxt = max_val;
        max_idx_nxt = max_idx;
        if (cnt == '0 || in_data > max_val) begin
            max_val_nxt = in_data;
            max_idx_nxt = cnt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE:    if (start) state_nxt = gt_bad ? DONE : ACCUM;
            ACCUM: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (last_xfer) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gt_lat     <= '0;
            cnt        <= '0;
            acc        <= '0;
            max_val    <= '0;
            max_idx    <= '0;
            pred_class <= '0;
            correct    <= 1'b0;
            loss       <= '0;
`ifdef GT_CHECK_EN
            err_gt     <= 1'b0;
`endif
        end else if (start_ok) begin
            gt_lat  <= ground_truth;
            cnt     <= '0;
            acc     <= '0;
            max_val <= '0;
            max_idx <= '0;
            if (gt_bad) begin
                pred_class <= '0;
                correct    <= 1'b0;
                loss       <= '1;
`ifdef GT_CHECK_EN
                err_gt     <= 1'b1;
`endif
            end
        end else if (xfer) begin
            cnt     <= cnt + 1'b1;
            acc     <= acc_nxt;
            max_val <= max_val_nxt;
            max_idx <= max_idx_nxt;
            if (last_xfer) begin
                pred_class <= max_idx_nxt;
                correct    <= gt_lat[max_idx_nxt];
                loss       <= acc_nxt;
`ifdef GT_CHECK_EN
                err_gt     <= 1'b0;
`endif
            end
        end
    end

endmodule

// File: tb/tb_fc_loss_unit.sv
// Directed bench for fc_loss_unit: expected results queued at start, compared on each done pulse.
// Covers the GT_CHECK_EN reject path when that macro is defined.
module tb_fc_loss_unit;

    typedef logic signed [31:0] img_t [10];
    typedef struct packed {
        logic [3:0]  pred;
        logic        correct;
        logic [31:0] loss;
        logic        err;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [9:0]        ground_truth;
    logic              in_valid;
    logic signed [31:0] in_data;
    logic              in_ready, busy, done, correct;
    logic [3:0]        pred_class;
    logic [31:0]       loss;
`ifdef GT_CHECK_EN
    logic              err_gt;
`endif

    int   checks = 0;
    int   errors = 0;
    int   done_count = 0;
    int   done_expect = 0;
    exp_t exp_q[$];

    fc_loss_unit dut (
        .clk(clk), .rst(rst), .start(start), .ground_truth(ground_truth),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .busy(busy), .done(done), .pred_class(pred_class), .correct(correct),
`ifdef GT_CHECK_EN
        .loss(loss), .err_gt(err_gt)
`else
        .loss(loss)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic exp_t model(input logic [9:0] gt, input img_t d);
        exp_t   m;
        longint acc, diff;
        int     best;
        acc  = 0;
        best = 0;
        for (int i = 0; i < 10; i++) begin
            diff = longint'(d[i]) - (gt[i] ? 64'sd256 : 64'sd0);
            acc  = acc + diff * diff;
            if (acc > 64'sh0FFFF_FFFF) acc = 64'sh0FFFF_FFFF;
            if (i > 0 && d[i] > d[best]) best = i;
        end
        m.pred    = 4'(best);
        m.correct = gt[best];
        m.loss    = acc[31:0];
        m.err     = 1'b0;
        return m;
    endfunction

    always @(negedge clk) begin
        if (!rst && done) begin
            exp_t e;
            done_count++;
            check("done_has_expectation", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("pred_class", 64'(pred_class), 64'(e.pred));
                check("correct", 64'(correct), 64'(e.correct));
                check("loss", 64'(loss), 64'(e.loss));
`ifdef GT_CHECK_EN
                check("err_gt", 64'(err_gt), 64'(e.err));
`endif
            end
        end
    end

    task automatic send_image(input logic [9:0] gt, input img_t d, input exp_t e, input bit noisy);
        bit ok;
        exp_q.push_back(e);
        done_expect++;
        @(posedge clk); #1;
        start = 1'b1;
        ground_truth = gt;
        @(posedge clk); #1;
        start = 1'b0;
        ground_truth = ~gt;
        for (int i = 0; i < 10; i++) begin
            if (noisy) begin
                for (int g = 0; g < i % 4; g++) begin
                    in_valid = 1'b0;
                    in_data  = 32'sh0BAD_F00D;
                    start    = 1'b1;
                    ground_truth = 10'b1;
                    @(posedge clk); #1;
                    start = 1'b0;
                end
            end
            in_valid = 1'b1;
            in_data  = d[i];
            ok = 1'b0;
            for (int t = 0; t < 20 && !ok; t++) begin
                @(negedge clk);
                if (in_ready) ok = 1'b1;
                @(posedge clk); #1;
            end
            check("in_ready_handshake", 64'(ok), 64'd1);
        end
        in_valid = 1'b0;
        if (noisy) begin
            start = 1'b1;
            ground_truth = 10'b1;
        end
        @(negedge clk);
        check("done_after_last", 64'(done), 64'd1);
        check("busy_in_done", 64'(busy), 64'd0);
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("done_single_pulse", 64'(done), 64'd0);
        check("idle_in_ready", 64'(in_ready), 64'd0);
    endtask

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog_timeout observed=running expected=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end

    initial begin
        img_t d;
        exp_t e;
        int   dc;

        rst = 1'b1;
        start = 1'b0;
        ground_truth = '0;
        in_valid = 1'b0;
        in_data = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_pred_class", 64'(pred_class), 64'd0);
        check("rst_loss", 64'(loss), 64'd0);
        check("rst_correct", 64'(correct), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) d[i] = (i == 0) ? 32'sd256 : 32'sd0;
        e = '{pred: 4'd0, correct: 1'b1, loss: 32'd0, err: 1'b0};
        send_image(10'b1, d, e, 1'b0);

        for (int i = 0; i < 10; i++) d[i] = 32'(10 * i);
        e = '{pred: 4'd9, correct: 1'b0, loss: 32'd78676, err: 1'b0};
        send_image(10'b1000, d, e, 1'b0);

        for (int i = 0; i < 10; i++) d[i] = 32'sd5;
        e = '{pred: 4'd0, correct: 1'b0, loss: 32'd63226, err: 1'b0};
        send_image(10'b100, d, e, 1'b0);

        for (int i = 0; i < 10; i++) d[i] = 32'sh7FFF_FFFF;
        e = '{pred: 4'd0, correct: 1'b1, loss: 32'hFFFF_FFFF, err: 1'b0};
        send_image(10'b1, d, e, 1'b0);

        for (int i = 0; i < 10; i++) d[i] = 32'(10 * i);
        e = '{pred: 4'd9, correct: 1'b0, loss: 32'd78676, err: 1'b0};
        send_image(10'b1000, d, e, 1'b1);

        for (int i = 0; i < 10; i++) d[i] = 32'($urandom_range(0, 2000)) - 32'sd1000;
        d[6] = 32'sd1500;
        send_image(10'b1000000, d, model(10'b1000000, d), 1'b0);

        for (int i = 0; i < 10; i++) d[i] = (i % 3 == 0) ? -32'sd40000 : 32'($urandom_range(0, 300));
        send_image(10'b10_0000_0000, d, model(10'b10_0000_0000, d), 1'b0);

`ifndef GT_CHECK_EN
        for (int i = 0; i < 10; i++) d[i] = 32'(10 * i);
        send_image(10'b0, d, model(10'b0, d), 1'b0);
`else
        exp_q.push_back('{pred: 4'd0, correct: 1'b0, loss: 32'hFFFF_FFFF, err: 1'b1});
        done_expect++;
        @(posedge clk); #1;
        start = 1'b1;
        ground_truth = 10'b11;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("gt_err_done", 64'(done), 64'd1);
        check("gt_err_flag", 64'(err_gt), 64'd1);
        check("gt_err_loss", 64'(loss), 64'hFFFF_FFFF);
        check("gt_err_in_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        check("gt_err_single_done", 64'(done), 64'd0);
        check("gt_err_idle_ready", 64'(in_ready), 64'd0);
`endif

        // Abort mid-image: results from the previous image must clear, no done afterwards.
        for (int i = 0; i < 10; i++) d[i] = 32'(10 * i);
        e = '{pred: 4'd9, correct: 1'b0, loss: 32'd78676, err: 1'b0};
        send_image(10'b1000, d, e, 1'b0);
        check("pre_abort_loss", 64'(loss), 64'd78676);
        dc = done_count;
        @(posedge clk); #1;
        start = 1'b1;
        ground_truth = 10'b1000;
        @(posedge clk); #1;
        start = 1'b0;
        in_valid = 1'b1;
        in_data = 32'sd7;
        repeat (4) @(posedge clk);
        #2;
        check("accum_busy_before_abort", 64'(busy), 64'd1);
        rst = 1'b1;
        #1;
        check("abort_pred_class", 64'(pred_class), 64'd0);
        check("abort_loss", 64'(loss), 64'd0);
        check("abort_correct", 64'(correct), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_in_ready", 64'(in_ready), 64'd0);
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        check("abort_no_done", 64'(done_count), 64'(dc));
        check("abort_idle_ready", 64'(in_ready), 64'd0);

        check("done_pulse_count", 64'(done_count), 64'(done_expect));
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
